// File: rtl/side_effect_arbiter.sv
// side_effect_arbiter: serialises side-effecting calls (display, DPI void,
// DPI with return value) from NUM_REQ processes onto a single host channel.
// Requesters are served round-robin, one call in flight at a time. Each call
// completes with a one-cycle rsp_valid pulse to its requester.
module side_effect_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ARG_W   = 32,
    parameter int TIMEOUT = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req_valid,
    input  logic [2*NUM_REQ-1:0]       req_kind,
    input  logic [ARG_W*NUM_REQ-1:0]   req_arg,
    output logic [NUM_REQ-1:0]         req_ready,
    output logic [NUM_REQ-1:0]         rsp_valid,
    output logic [ARG_W-1:0]           rsp_data,
    output logic                       host_valid,
    input  logic                       host_ready,
    output logic [$clog2(NUM_REQ)-1:0] host_id,
    output logic [1:0]                 host_kind,
    output logic [ARG_W-1:0]           host_arg,
    input  logic                       host_done,
    input  logic [ARG_W-1:0]           host_ret,
    input  logic                       err_clr,
    output logic                       err_timeout,
    output logic                       err_kind
);

    localparam int              ID_W      = $clog2(NUM_REQ);
    localparam logic [ID_W:0]   NUM_REQ_L = (ID_W+1)'(NUM_REQ);
    localparam logic [15:0]     TIMEOUT_L = 16'(TIMEOUT);

    localparam logic [1:0] KIND_DISPLAY = 2'b00;
    localparam logic [1:0] KIND_RET     = 2'b10;
    localparam logic [1:0] KIND_RSVD    = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    state_t             state;
    logic [ID_W-1:0]    ptr;
    logic [15:0]        count;

    logic               win_found;
    logic [ID_W-1:0]    win_id;
    logic [ID_W-1:0]    cand;
    logic [1:0]         win_kind;
    logic [ARG_W-1:0]   win_arg;

    // Reduce a value in [0, 2*NUM_REQ) to a requester index.
    function automatic logic [ID_W-1:0] wrap_id(input logic [ID_W:0] v);
        if (v >= NUM_REQ_L) begin
            return ID_W'(v - NUM_REQ_L);
        end
        return ID_W'(v);
    endfunction

    function automatic logic [NUM_REQ-1:0] onehot(input logic [ID_W-1:0] id);
        return NUM_REQ'(1) << id;
    endfunction

    // Round-robin search: first asserted requester at or above ptr, wrapping.
    always_comb begin
        win_found = 1'b0;
        win_id    = '0;
        cand      = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            cand = wrap_id({1'b0, ptr} + (ID_W+1)'(i));
            if (!win_found && req_valid[cand]) begin
                win_found = 1'b1;
                win_id    = cand;
            end
        end
    end

    // Pick the winner's kind and argument out of the packed request buses.
    always_comb begin
        win_kind = '0;
        win_arg  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (win_id == ID_W'(i)) begin
                win_kind = req_kind[2*i +: 2];
                win_arg  = req_arg[ARG_W*i +: ARG_W];
            end
        end
    end

    // Grant only while idle; held low during reset so every output reads 0.
    always_comb begin
        req_ready = '0;
        if (rst_n && state == IDLE && win_found) begin
            req_ready = onehot(win_id);
        end
    end

    // Call-sequencing FSM with all host/response/error outputs registered.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= IDLE;
            ptr         <= '0;
            count       <= '0;
            rsp_valid   <= '0;
            rsp_data    <= '0;
            host_valid  <= 1'b0;
            host_id     <= '0;
            host_kind   <= '0;
            host_arg    <= '0;
            err_timeout <= 1'b0;
            err_kind    <= 1'b0;
        end else begin
            rsp_valid <= '0;

            // Clear first so that any set further down in this cycle wins.
            if (err_clr) begin
                err_timeout <= 1'b0;
                err_kind    <= 1'b0;
            end

            case (state)
                IDLE: begin
                    if (win_found) begin
                        host_id   <= win_id;
                        host_kind <= win_kind;
                        host_arg  <= win_arg;
                        ptr       <= wrap_id({1'b0, win_id} + (ID_W+1)'(1));
                        if (win_kind == KIND_RSVD) begin
                            // Reserved kind never reaches the host; answer it at once.
                            err_kind  <= 1'b1;
                            rsp_data  <= '0;
                            rsp_valid <= onehot(win_id);
                            state     <= RESP;
                        end else begin
                            host_valid <= 1'b1;
                            state      <= ISSUE;
                        end
                    end
                end

                ISSUE: begin
                    if (host_ready) begin
                        host_valid <= 1'b0;
                        if (host_kind == KIND_DISPLAY) begin
                            // Display needs no completion from the host.
                            rsp_data  <= '0;
                            rsp_valid <= onehot(host_id);
                            state     <= RESP;
                        end else begin
                            count <= '0;
                            state <= WAIT;
                        end
                    end
                end

                WAIT: begin
                    if (host_done) begin
                        // Completion wins over a coinciding timeout expiry.
                        rsp_data  <= (host_kind == KIND_RET) ? host_ret : '0;
                        rsp_valid <= onehot(host_id);
                        state     <= RESP;
                    end else if (count == TIMEOUT_L) begin
                        err_timeout <= 1'b1;
                        rsp_data    <= '0;
                        rsp_valid   <= onehot(host_id);
                        state       <= RESP;
                    end else begin
                        count <= count + 16'd1;
                    end
                end

                RESP: begin
                    count <= '0;
                    state <= IDLE;
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/side_effect_arbiter.md
SIDE_EFFECT_ARBITER -- requirements
Module: side_effect_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4, meaning number of requesting processes (2..8).
REQ-002 SHALL have parameter ARG_W, default 32, meaning argument/return width in bits.
REQ-003 SHALL have parameter TIMEOUT, default 255, meaning maximum WAIT cycles before abort (1..65535).
REQ-004 SHALL have port clk, input, 1, meaning the single clock; all state on rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning the reset; asynchronous, active-low.
REQ-006 SHALL have port req_valid, input, NUM_REQ, meaning per-requester call pending.
REQ-007 SHALL have port req_kind, input, 2*NUM_REQ, meaning per-requester kind: 00 display, 01 DPI void, 10 DPI return, 11 reserved.
REQ-008 SHALL have port req_arg, input, ARG_W*NUM_REQ, meaning per-requester argument.
REQ-009 SHALL have port req_ready, output, NUM_REQ, meaning one-hot acceptance.
REQ-010 SHALL have port rsp_valid, output, NUM_REQ, meaning one-hot completion pulse.
REQ-011 SHALL have port rsp_data, output, ARG_W, meaning return value, qualified by rsp_valid.
REQ-012 SHALL have port host_valid, output, 1, meaning call offered to host channel.
REQ-013 SHALL have port host_ready, input, 1, meaning host accepts the offered call.
REQ-014 SHALL have port host_id, output, clog2(NUM_REQ), meaning requester index.
REQ-015 SHALL have port host_kind, output, 2, meaning captured kind.
REQ-016 SHALL have port host_arg, output, ARG_W, meaning captured argument.
REQ-017 SHALL have port host_done, input, 1, meaning host finished call.
REQ-018 SHALL have port host_ret, input, ARG_W, meaning return value, qualified by host_done.
REQ-019 SHALL have port err_clr, input, 1, meaning clears sticky error flags.
REQ-020 SHALL have port err_timeout, output, 1, meaning sticky, a WAIT exceeded TIMEOUT.
REQ-021 SHALL have port err_kind, output, 1, meaning sticky, reserved kind 11 accepted.

Function
REQ-022 SHALL implement FSM states IDLE, ISSUE, WAIT, RESP; exactly one call in flight.
REQ-023 SHALL, in IDLE, select winner round-robin among asserted req_valid, starting at pointer ptr and searching upward with wrap.
REQ-024 SHALL drive req_ready combinationally, one-hot winner, only in IDLE; accept = req_valid&req_ready.
REQ-025 SHALL on accept capture id/kind/arg, set ptr = winner+1 mod NUM_REQ, go ISSUE.
REQ-026 SHALL on accept of kind 11 set err_kind, pulse rsp_valid[winner] next cycle with rsp_data=0, return to IDLE, never assert host_valid.
REQ-027 SHALL in ISSUE hold host_valid=1 and host_id/kind/arg stable until host_ready; no timeout in ISSUE.
REQ-028 SHALL on ISSUE handshake go RESP for kind 00 (display is fire-and-forget), else WAIT.
REQ-029 SHALL in WAIT count cycles from 0; on host_done capture host_ret (kind 10) or zero (kind 01), go RESP.
REQ-030 SHALL when count reaches TIMEOUT without host_done set err_timeout, rsp_data=0, go RESP.
REQ-031 SHALL, when host_done and the timeout expiry coincide, honour host_done and leave err_timeout unchanged.
REQ-032 SHALL ignore host_done outside WAIT.
REQ-033 SHALL in RESP pulse rsp_valid[id] for exactly one cycle, then go IDLE; the next grant occurs no earlier than the IDLE cycle.
REQ-034 SHALL hold rsp_data until the next RESP.
REQ-035 SHALL give err_clr priority below a same-cycle set (set wins).
REQ-036 SHALL achieve minimum latency accept->rsp_valid of 2 cycles for display when host_ready=1.

Reset
REQ-037 SHALL on rst_n low immediately force IDLE, ptr=0, count=0, and all outputs 0, including mid-ISSUE/WAIT; the in-flight call is dropped with no rsp_valid.
REQ-038 SHALL accept no request in the first cycle after rst_n deasserts only if the FSM is not in IDLE (i.e., IDLE grants are permitted that cycle).

Verification
REQ-039 SHALL cover round-robin: req_valid=1111 held, instant host -> grants in order 0,1,2,3,0 with ptr wrap.
REQ-040 SHALL cover DPI return: req 2 kind 10 arg 0x5, host_done after 3 cycles with host_ret 0xA -> rsp_valid=0100, rsp_data=0xA, err flags 0.
REQ-041 SHALL cover timeout: TIMEOUT=4, kind 01, host_done never asserted -> rsp_valid 5 cycles after entering WAIT, rsp_data=0, err_timeout=1 until err_clr.
REQ-042 SHALL cover the simultaneous case: host_done at count==TIMEOUT -> rsp_data=host_ret, err_timeout stays 0.
REQ-043 SHALL cover backpressure: host_ready low for 10 cycles -> host_valid/arg stable, no timeout, no error.
REQ-044 SHALL cover reset mid-WAIT: rst_n low for 1 cycle -> all outputs 0 at once, no rsp_valid, the next grant goes to the lowest-index valid requester.
